// File: rtl/exc_ctrl_unit.sv
// exc_ctrl_unit: registered M-stage exception/ERET resolver. It synchronises
// the interrupt lines, forwards CP0 writes and redirects fetch by handshake.
// Optional macro TIMER_INT_EN: adds CP0 Count/Compare and the timer interrupt.
// Ports: clk, resetn (async, active-low)
//   M stage : inst_valid_i, pc_i, in_delay_slot_i, exc_vec_i, mem_vaddr_i
//   irq     : hw_int_i -> ip_o, timer_int_o
//   CP0     : status_i/cause_i/epc_i, cp0_we_i/cp0_waddr_i/cp0_wdata_i
//   commit  : exc_valid_o, exc_code_o, eret_o, exc_epc_o, exc_bd_o,
//             badvaddr_we_o, exc_badvaddr_o
//   fetch   : flush_o, redirect_valid_o, redirect_pc_o, redirect_ready_i
module exc_ctrl_unit #(
   parameter int          NUM_HW_INT  = 6,
   parameter logic [31:0] EXC_ENTRY   = 32'hBFC00380,
   parameter int          SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  inst_valid_i,
   input  logic [31:0]           pc_i,
   input  logic                  in_delay_slot_i,
   input  logic [7:0]            exc_vec_i,
   input  logic [31:0]           mem_vaddr_i,
   input  logic [NUM_HW_INT-1:0] hw_int_i,
   input  logic [31:0]           status_i,
   input  logic [31:0]           cause_i,
   input  logic [31:0]           epc_i,
   input  logic                  cp0_we_i,
   input  logic [4:0]            cp0_waddr_i,
   input  logic [31:0]           cp0_wdata_i,
   output logic                  flush_o,
   output logic                  exc_valid_o,
   output logic [4:0]            exc_code_o,
   output logic                  eret_o,
   output logic [31:0]           exc_epc_o,
   output logic                  exc_bd_o,
   output logic                  badvaddr_we_o,
   output logic [31:0]           exc_badvaddr_o,
   output logic [5:0]            ip_o,
   output logic                  redirect_valid_o,
   output logic [31:0]           redirect_pc_o,
   input  logic                  redirect_ready_i,
   output logic                  timer_int_o
);

   localparam logic [4:0] C_INT  = 5'h00;
   localparam logic [4:0] C_ADEL = 5'h04;
   localparam logic [4:0] C_ADES = 5'h05;
   localparam logic [4:0] C_SYS  = 5'h08;
   localparam logic [4:0] C_BP   = 5'h09;
   localparam logic [4:0] C_RI   = 5'h0a;
   localparam logic [4:0] C_OV   = 5'h0c;

   localparam logic [4:0] A_COUNT   = 5'd9;
   localparam logic [4:0] A_COMPARE = 5'd11;
   localparam logic [4:0] A_STATUS  = 5'd12;
   localparam logic [4:0] A_CAUSE   = 5'd13;
   localparam logic [4:0] A_EPC     = 5'd14;

   typedef enum logic {
      S_IDLE,
      S_REDIR
   } state_t;

   state_t r_state, w_state_nxt;

   logic [NUM_HW_INT-1:0] r_sync [SYNC_STAGES];
   logic [5:0]            w_ip;
   logic                  w_timer;

   logic [31:0] w_status, w_cause, w_epc;
   logic        w_int;
   logic        w_unused;

   logic        w_event, w_eret, w_bvwe;
   logic [4:0]  w_code;
   logic [31:0] w_bv;

   logic        r_flush, r_evalid, r_eret, r_bd, r_bvwe, r_rvalid;
   logic [4:0]  r_code;
   logic [31:0] r_epc, r_bv, r_rpc;

   logic        w_flush_nxt, w_evalid_nxt, w_eret_nxt, w_bd_nxt;
   logic        w_bvwe_nxt, w_rvalid_nxt;
   logic [4:0]  w_code_nxt;
   logic [31:0] w_epc_nxt, w_bv_nxt, w_rpc_nxt;

   // Interrupt synchroniser chain
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            r_sync[i] <= '0;
         end
      end else begin
         r_sync[0] <= hw_int_i;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
         end
      end
   end

`ifdef TIMER_INT_EN
   logic        r_tick;
   logic        r_timer;
   logic [31:0] r_count;
   logic [31:0] r_compare;
   logic        w_wr_count, w_wr_cmp;

   assign w_wr_count = cp0_we_i && (cp0_waddr_i == A_COUNT);
   assign w_wr_cmp   = cp0_we_i && (cp0_waddr_i == A_COMPARE);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_tick    <= 1'b0;
         r_timer   <= 1'b0;
         r_count   <= '0;
         r_compare <= '0;
      end else begin
         r_tick <= ~r_tick;
         if (w_wr_count) begin
            r_count <= cp0_wdata_i;
         end else if (r_tick) begin
            r_count <= r_count + 32'd1;
         end
         // Compare write acknowledges the timer interrupt
         if (w_wr_cmp) begin
            r_compare <= cp0_wdata_i;
            r_timer   <= 1'b0;
         end else if ((r_compare != '0) && (r_count == r_compare)) begin
            r_timer <= 1'b1;
         end
      end
   end

   assign w_timer = r_timer;
`else
   assign w_timer = 1'b0;
`endif

   always_comb begin
      w_ip = '0;
      w_ip[NUM_HW_INT-1:0] = r_sync[SYNC_STAGES-1];
      w_ip[5] = w_ip[5] | w_timer;
   end

   // Forward the W-stage CP0 write over the committed value
   always_comb begin
      w_status = status_i;
      w_cause  = cause_i;
      w_epc    = epc_i;
      if (cp0_we_i && (cp0_waddr_i == A_STATUS)) w_status = cp0_wdata_i;
      if (cp0_we_i && (cp0_waddr_i == A_CAUSE))  w_cause  = cp0_wdata_i;
      if (cp0_we_i && (cp0_waddr_i == A_EPC))    w_epc    = cp0_wdata_i;
   end

   assign w_unused = ^{w_status[31:16], w_status[7:2],
                       w_cause[31:10], w_cause[7:0]};

   assign w_int = inst_valid_i
                & (((w_ip & w_status[15:10]) != '0)
                 | ((w_cause[9:8] & w_status[9:8]) != '0))
                & w_status[0] & ~w_status[1];

   // Fixed-priority resolution; only the winner is reported
   always_comb begin
      w_event = 1'b0;
      w_code  = C_INT;
      w_eret  = 1'b0;
      w_bvwe  = 1'b0;
      w_bv    = '0;
      if (inst_valid_i) begin
         w_event = 1'b1;
         if (w_int) begin
            w_code = C_INT;
         end else if (exc_vec_i[7]) begin
            w_code = C_ADEL;
            w_bvwe = 1'b1;
            w_bv   = pc_i;
         end else if (exc_vec_i[1]) begin
            w_code = C_RI;
         end else if (exc_vec_i[0]) begin
            w_code = C_OV;
         end else if (exc_vec_i[4]) begin
            w_code = C_SYS;
         end else if (exc_vec_i[3]) begin
            w_code = C_BP;
         end else if (exc_vec_i[6]) begin
            w_code = C_ADEL;
            w_bvwe = 1'b1;
            w_bv   = mem_vaddr_i;
         end else if (exc_vec_i[5]) begin
            w_code = C_ADES;
            w_bvwe = 1'b1;
            w_bv   = mem_vaddr_i;
         end else if (exc_vec_i[2]) begin
            w_eret = 1'b1;
         end else begin
            w_event = 1'b0;
         end
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_flush_nxt  = r_flush;
      w_rvalid_nxt = r_rvalid;
      w_evalid_nxt = 1'b0;
      w_bvwe_nxt   = 1'b0;
      w_code_nxt   = r_code;
      w_eret_nxt   = r_eret;
      w_epc_nxt    = r_epc;
      w_bd_nxt     = r_bd;
      w_bv_nxt     = r_bv;
      w_rpc_nxt    = r_rpc;
      unique case (r_state)
         S_IDLE: begin
            if (w_event) begin
               w_state_nxt  = S_REDIR;
               w_flush_nxt  = 1'b1;
               w_rvalid_nxt = 1'b1;
               w_evalid_nxt = 1'b1;
               w_bvwe_nxt   = w_bvwe;
               w_code_nxt   = w_code;
               w_eret_nxt   = w_eret;
               w_epc_nxt    = in_delay_slot_i ? (pc_i - 32'd4) : pc_i;
               w_bd_nxt     = in_delay_slot_i;
               w_bv_nxt     = w_bv;
               w_rpc_nxt    = w_eret ? w_epc : EXC_ENTRY;
            end
         end
         S_REDIR: begin
            // M-stage inputs ignored here: the pipeline is being flushed
            if (redirect_ready_i) begin
               w_state_nxt  = S_IDLE;
               w_flush_nxt  = 1'b0;
               w_rvalid_nxt = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state  <= S_IDLE;
         r_flush  <= 1'b0;
         r_rvalid <= 1'b0;
         r_evalid <= 1'b0;
         r_bvwe   <= 1'b0;
         r_code   <= '0;
         r_eret   <= 1'b0;
         r_epc    <= '0;
         r_bd     <= 1'b0;
         r_bv     <= '0;
         r_rpc    <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_flush  <= w_flush_nxt;
         r_rvalid <= w_rvalid_nxt;
         r_evalid <= w_evalid_nxt;
         r_bvwe   <= w_bvwe_nxt;
         r_code   <= w_code_nxt;
         r_eret   <= w_eret_nxt;
         r_epc    <= w_epc_nxt;
         r_bd     <= w_bd_nxt;
         r_bv     <= w_bv_nxt;
         r_rpc    <= w_rpc_nxt;
      end
   end

   assign flush_o          = r_flush;
   assign exc_valid_o      = r_evalid;
   assign exc_code_o       = r_code;
   assign eret_o           = r_eret;
   assign exc_epc_o        = r_epc;
   assign exc_bd_o         = r_bd;
   assign badvaddr_we_o    = r_bvwe;
   assign exc_badvaddr_o   = r_bv;
   assign ip_o             = w_ip;
   assign redirect_valid_o = r_rvalid;
   assign redirect_pc_o    = r_rpc;
   assign timer_int_o      = w_timer;

endmodule

// File: tb/tb_exc_ctrl_unit.sv
// tb_exc_ctrl_unit: scoreboard bench for exc_ctrl_unit.
// Expected commits are queued at issue and popped on each exc_valid_o pulse.
module tb_exc_ctrl_unit;

   localparam logic [31:0] ENTRY = 32'hBFC00380;

   logic        clk;
   logic        resetn;
   logic        inst_valid_i;
   logic [31:0] pc_i;
   logic        in_delay_slot_i;
   logic [7:0]  exc_vec_i;
   logic [31:0] mem_vaddr_i;
   logic [5:0]  hw_int_i;
   logic [31:0] status_i, cause_i, epc_i;
   logic        cp0_we_i;
   logic [4:0]  cp0_waddr_i;
   logic [31:0] cp0_wdata_i;
   logic        flush_o, exc_valid_o, eret_o, exc_bd_o, badvaddr_we_o;
   logic [4:0]  exc_code_o;
   logic [31:0] exc_epc_o, exc_badvaddr_o, redirect_pc_o;
   logic [5:0]  ip_o;
   logic        redirect_valid_o, redirect_ready_i, timer_int_o;

   exc_ctrl_unit dut (
      .clk              (clk),
      .resetn           (resetn),
      .inst_valid_i     (inst_valid_i),
      .pc_i             (pc_i),
      .in_delay_slot_i  (in_delay_slot_i),
      .exc_vec_i        (exc_vec_i),
      .mem_vaddr_i      (mem_vaddr_i),
      .hw_int_i         (hw_int_i),
      .status_i         (status_i),
      .cause_i          (cause_i),
      .epc_i            (epc_i),
      .cp0_we_i         (cp0_we_i),
      .cp0_waddr_i      (cp0_waddr_i),
      .cp0_wdata_i      (cp0_wdata_i),
      .flush_o          (flush_o),
      .exc_valid_o      (exc_valid_o),
      .exc_code_o       (exc_code_o),
      .eret_o           (eret_o),
      .exc_epc_o        (exc_epc_o),
      .exc_bd_o         (exc_bd_o),
      .badvaddr_we_o    (badvaddr_we_o),
      .exc_badvaddr_o   (exc_badvaddr_o),
      .ip_o             (ip_o),
      .redirect_valid_o (redirect_valid_o),
      .redirect_pc_o    (redirect_pc_o),
      .redirect_ready_i (redirect_ready_i),
      .timer_int_o      (timer_int_o)
   );

   typedef struct {
      logic [4:0]  code;
      logic        eret;
      logic [31:0] epc;
      logic        bd;
      logic        bvwe;
      logic [31:0] bv;
      logic [31:0] rpc;
   } exp_t;

   exp_t sb[$];
   exp_t m_e;
   int   n_err = 0;
   int   n_chk = 0;
   logic prev_ev = 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s act=%h exp=%h", tag, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic [4:0] code, input logic eret,
                               input logic [31:0] epc, input logic bd,
                               input logic bvwe, input logic [31:0] bv,
                               input logic [31:0] rpc);
      exp_t e;
      e.code = code; e.eret = eret; e.epc = epc; e.bd = bd;
      e.bvwe = bvwe; e.bv = bv; e.rpc = rpc;
      return e;
   endfunction

   // Scoreboard consumer: every commit pulse must match the queue head
   always @(negedge clk) begin
      if (exc_valid_o) begin
         chk("evalid_pulse", {31'd0, prev_ev}, 32'd0);
         if (sb.size() == 0) begin
            chk("unexpected_evt", 32'd1, 32'd0);
         end else begin
            m_e = sb.pop_front();
            chk("code", {27'd0, exc_code_o}, {27'd0, m_e.code});
            chk("eret", {31'd0, eret_o}, {31'd0, m_e.eret});
            chk("epc", exc_epc_o, m_e.epc);
            chk("bd", {31'd0, exc_bd_o}, {31'd0, m_e.bd});
            chk("bvwe", {31'd0, badvaddr_we_o}, {31'd0, m_e.bvwe});
            if (m_e.bvwe) chk("badvaddr", exc_badvaddr_o, m_e.bv);
            chk("rpc", redirect_pc_o, m_e.rpc);
            chk("flush_on", {31'd0, flush_o}, 32'd1);
            chk("rvalid_on", {31'd0, redirect_valid_o}, 32'd1);
         end
      end
      prev_ev = exc_valid_o;
   end

   task automatic issue(input logic [7:0] vec, input logic [31:0] pc,
                        input logic ds, input logic [31:0] va);
      @(negedge clk);
      exc_vec_i = vec;
      pc_i = pc;
      in_delay_slot_i = ds;
      mem_vaddr_i = va;
      inst_valid_i = 1'b1;
      @(posedge clk);
      #1;
      inst_valid_i = 1'b0;
      exc_vec_i = '0;
      in_delay_slot_i = 1'b0;
      cp0_we_i = 1'b0;
   endtask

   task automatic complete(input int stall, input logic [31:0] rpc,
                           input logic do_rst);
      int n;
      n = 0;
      @(negedge clk);
      while (!redirect_valid_o && n < 8) begin
         @(negedge clk);
         n++;
      end
      chk("redir_seen", {31'd0, redirect_valid_o}, 32'd1);
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         chk("hold_valid", {31'd0, redirect_valid_o}, 32'd1);
         chk("hold_pc", redirect_pc_o, rpc);
         chk("hold_flush", {31'd0, flush_o}, 32'd1);
         chk("evalid_once", {31'd0, exc_valid_o}, 32'd0);
      end
      if (do_rst) begin
         resetn = 1'b0;
         #1;
         chk("rst_flush", {31'd0, flush_o}, 32'd0);
         chk("rst_rvalid", {31'd0, redirect_valid_o}, 32'd0);
         chk("rst_rpc", redirect_pc_o, 32'd0);
         chk("rst_code", {27'd0, exc_code_o}, 32'd0);
         chk("rst_epc", exc_epc_o, 32'd0);
         chk("rst_bd", {31'd0, exc_bd_o}, 32'd0);
         @(negedge clk);
         resetn = 1'b1;
      end else begin
         redirect_ready_i = 1'b1;
         @(posedge clk);
         #1;
         redirect_ready_i = 1'b0;
         @(negedge clk);
         chk("drop_valid", {31'd0, redirect_valid_o}, 32'd0);
         chk("drop_flush", {31'd0, flush_o}, 32'd0);
      end
      chk("sb_drained", sb.size(), 32'd0);
   endtask

   task automatic cp0_wr(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      cp0_we_i = 1'b1;
      cp0_waddr_i = a;
      cp0_wdata_i = d;
      @(negedge clk);
      cp0_we_i = 1'b0;
   endtask

   initial begin
      int n;
      resetn = 1'b1;
      inst_valid_i = 1'b0;
      pc_i = '0;
      in_delay_slot_i = 1'b0;
      exc_vec_i = '0;
      mem_vaddr_i = '0;
      hw_int_i = '0;
      status_i = '0;
      cause_i = '0;
      epc_i = '0;
      cp0_we_i = 1'b0;
      cp0_waddr_i = '0;
      cp0_wdata_i = '0;
      redirect_ready_i = 1'b0;
      #2 resetn = 1'b0;
      #1;
      chk("rst0_flush", {31'd0, flush_o}, 32'd0);
      chk("rst0_evalid", {31'd0, exc_valid_o}, 32'd0);
      chk("rst0_rvalid", {31'd0, redirect_valid_o}, 32'd0);
      chk("rst0_ip", {26'd0, ip_o}, 32'd0);
      chk("rst0_timer", {31'd0, timer_int_o}, 32'd0);
      chk("rst0_bvwe", {31'd0, badvaddr_we_o}, 32'd0);
      repeat (2) @(negedge clk);
      resetn = 1'b1;

      // ERET from committed EPC, then from forwarded EPC
      epc_i = 32'h8000_0200;
      sb.push_back(mk(5'h00, 1, 32'h8000_0100, 0, 0, 0, 32'h8000_0200));
      issue(8'h04, 32'h8000_0100, 1'b0, 32'h0);
      complete(0, 32'h8000_0200, 1'b0);
      cp0_we_i = 1'b1;
      cp0_waddr_i = 5'd14;
      cp0_wdata_i = 32'h8000_0300;
      sb.push_back(mk(5'h00, 1, 32'h8000_0100, 0, 0, 0, 32'h8000_0300));
      issue(8'h04, 32'h8000_0100, 1'b0, 32'h0);
      complete(0, 32'h8000_0300, 1'b0);

      // Delay-slot overflow
      sb.push_back(mk(5'h0c, 0, 32'h8000_1000, 1, 0, 0, ENTRY));
      issue(8'h01, 32'h8000_1004, 1'b1, 32'h0);
      complete(1, ENTRY, 1'b0);

      // Syscall beats AdES; AdES alone
      sb.push_back(mk(5'h08, 0, 32'h8000_0040, 0, 0, 0, ENTRY));
      issue(8'h30, 32'h8000_0040, 1'b0, 32'h0000_0003);
      complete(0, ENTRY, 1'b0);
      sb.push_back(mk(5'h05, 0, 32'h8000_0040, 0, 1, 32'h3, ENTRY));
      issue(8'h20, 32'h8000_0040, 1'b0, 32'h0000_0003);
      complete(0, ENTRY, 1'b0);

      // AdEL-fetch on the ERET itself; RI over Ov; AdEL-data
      sb.push_back(mk(5'h04, 0, 32'h8000_0081, 0, 1, 32'h8000_0081, ENTRY));
      issue(8'h84, 32'h8000_0081, 1'b0, 32'h0000_0010);
      complete(0, ENTRY, 1'b0);
      sb.push_back(mk(5'h0a, 0, 32'h8000_0500, 0, 0, 0, ENTRY));
      issue(8'h03, 32'h8000_0500, 1'b0, 32'h0);
      complete(0, ENTRY, 1'b0);
      sb.push_back(mk(5'h04, 0, 32'h8000_0600, 0, 1, 32'h1234_5672, ENTRY));
      issue(8'h68, 32'h8000_0600, 1'b0, 32'h1234_5672);
      sb[0].code = 5'h09;
      sb[0].bvwe = 1'b0;
      complete(0, ENTRY, 1'b0);
      sb.push_back(mk(5'h04, 0, 32'h8000_0604, 0, 1, 32'h1234_5672, ENTRY));
      issue(8'h60, 32'h8000_0604, 1'b0, 32'h1234_5672);
      complete(0, ENTRY, 1'b0);

      // Interrupt synchroniser latency and pre-emption
      status_i = 32'h0000_0401;
      @(negedge clk);
      hw_int_i[0] = 1'b1;
      @(negedge clk);
      chk("ip_lat1", {26'd0, ip_o}, 32'd0);
      @(negedge clk);
      chk("ip_lat2", {26'd0, ip_o}, 32'd1);
      sb.push_back(mk(5'h00, 0, 32'h8000_0700, 0, 0, 0, ENTRY));
      issue(8'h00, 32'h8000_0700, 1'b0, 32'h0);
      complete(0, ENTRY, 1'b0);
      sb.push_back(mk(5'h00, 0, 32'h8000_0704, 0, 0, 0, ENTRY));
      issue(8'h80, 32'h8000_0704, 1'b0, 32'h0);
      complete(0, ENTRY, 1'b0);
      status_i = 32'h0000_0403;
      issue(8'h00, 32'h8000_0708, 1'b0, 32'h0);
      repeat (3) @(negedge clk);
      chk("exl_no_evt", {31'd0, redirect_valid_o}, 32'd0);
      hw_int_i = '0;
      status_i = '0;
      repeat (3) @(negedge clk);
      chk("ip_clear", {26'd0, ip_o}, 32'd0);

      // Long stall, then reset during the wait
      sb.push_back(mk(5'h09, 0, 32'h8000_0800, 0, 0, 0, ENTRY));
      issue(8'h08, 32'h8000_0800, 1'b0, 32'h0);
      complete(3, ENTRY, 1'b0);
      sb.push_back(mk(5'h09, 0, 32'h8000_2000, 1, 0, 0, ENTRY));
      issue(8'h08, 32'h8000_2004, 1'b1, 32'h0);
      complete(2, ENTRY, 1'b1);

      // Timer
      cp0_wr(5'd9, 32'd0);
      cp0_wr(5'd11, 32'd10);
`ifdef TIMER_INT_EN
      n = 0;
      while (!timer_int_o && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("timer_set", {31'd0, timer_int_o}, 32'd1);
      chk("timer_ip5", {31'd0, ip_o[5]}, 32'd1);
      cp0_wr(5'd11, 32'd1000);
      chk("timer_clr", {31'd0, timer_int_o}, 32'd0);
`else
      n = 0;
      repeat (30) @(negedge clk);
      chk("timer_off", {31'd0, timer_int_o}, 32'd0);
      chk("timer_ip5", {31'd0, ip_o[5]}, 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
